fx_eq_ctrl: RTL and testbench



---
 rtl/fx_pkg.sv | 25 ++
 rtl/fx_eq_ramp_step.sv | 45 ++++
 rtl/fx_eq_ctrl.sv | 134 +++++++++++++
 tb/tb_fx_eq_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// fx_pkg: shared types and defaults for the effects EQ controller.
// Build option: FX_EQ_RAMP_EN selects ramped band updates.
package fx_pkg;

  localparam int EQ_PARAM_W   = 7;
  localparam int EQ_RAMP_STEP = 4;

  localparam logic [EQ_PARAM_W-1:0] EQ_UNITY =
    {1'b1, {(EQ_PARAM_W-1){1'b0}}};

  typedef enum logic [1:0] {
    EQ_LOW  = 2'd0,
    EQ_MID  = 2'd1,
    EQ_HIGH = 2'd2,
    EQ_PRES = 2'd3
  } eq_band_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_EVAL  = 2'd2,
    ST_WRITE = 2'd3
  } fx_eq_ctrl_state_e;

endpackage

// File: rtl/fx_eq_ramp_step.sv
// fx_eq_ramp_step: next applied value for one band.
// FX_EQ_RAMP_EN limits each move to RAMP_STEP; otherwise jump to target.
module fx_eq_ramp_step
  import fx_pkg::*;
#(
  parameter int PARAM_W   = EQ_PARAM_W,
  parameter int RAMP_STEP = EQ_RAMP_STEP
) (
  input  logic [PARAM_W-1:0] cur,
  input  logic [PARAM_W-1:0] tgt,
  output logic [PARAM_W-1:0] next
);

`ifdef FX_EQ_RAMP_EN
  localparam bit RampOn = 1'b1;
`else
  localparam bit RampOn = 1'b0;
`endif

  localparam logic [PARAM_W-1:0] STEP =
    PARAM_W'(RAMP_STEP);

  logic               w_up;
  logic [PARAM_W-1:0] w_diff;
  logic               w_small;

  assign w_up   = tgt > cur;
  assign w_diff = w_up ? (tgt - cur)
                       : (cur - tgt);

  // A step larger than the gap would overshoot,
  // so the gap itself is taken instead.
  assign w_small =
    32'(w_diff) <= $unsigned(RAMP_STEP);

  // Far targets move one step; no wrap is possible
  // because the step is strictly inside the gap.
  always_comb begin
    next = tgt;
    if (RampOn && !w_small) begin
      next = w_up ? (cur + STEP) : (cur - STEP);
    end
  end

endmodule

// File: rtl/fx_eq_ctrl.sv
// fx_eq_ctrl: turns gain snapshots into EQ band writes.
// Build option: FX_EQ_RAMP_EN (ramped updates via fx_eq_ramp_step).
module fx_eq_ctrl
  import fx_pkg::*;
#(
  parameter int PARAM_W   = EQ_PARAM_W,
  parameter int RAMP_STEP = EQ_RAMP_STEP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_en,
  input  logic [PARAM_W-1:0] fx_low_gain,
  input  logic [PARAM_W-1:0] fx_mid_gain,
  input  logic [PARAM_W-1:0] fx_high_gain,
  input  logic [PARAM_W-1:0] fx_presence,
  output logic               coef_valid,
  input  logic               coef_ready,
  output logic [1:0]         coef_band,
  output logic [PARAM_W-1:0] coef_data,
  output logic               busy,
  output logic               overrun
);

  localparam logic [PARAM_W-1:0] UNITY =
    {1'b1, {(PARAM_W-1){1'b0}}};

  fx_eq_ctrl_state_e  r_state;
  logic [1:0]         r_idx;
  logic [PARAM_W-1:0] r_cur [4];
  logic [PARAM_W-1:0] r_tgt [4];
  logic               r_valid;
  eq_band_e           r_band;
  logic [PARAM_W-1:0] r_data;
  logic               r_ovr;

  logic [PARAM_W-1:0] w_cur;
  logic [PARAM_W-1:0] w_tgt;
  logic [PARAM_W-1:0] w_next;
  logic               w_last;
  logic               w_hs;

  assign w_cur  = r_cur[r_idx];
  assign w_tgt  = r_tgt[r_idx];
  assign w_last = (r_idx == 2'd3);
  assign w_hs   = r_valid & coef_ready;

  fx_eq_ramp_step #(
    .PARAM_W   (PARAM_W),
    .RAMP_STEP (RAMP_STEP)
  ) u_step (
    .cur  (w_cur),
    .tgt  (w_tgt),
    .next (w_next)
  );

  // Band sequencer: unity init, snapshot, per-band
  // compare and held write until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_idx   <= 2'd0;
      r_valid <= 1'b0;
      r_band  <= EQ_LOW;
      r_data  <= UNITY;
      for (int i = 0; i < 4; i++) begin
        r_cur[i] <= UNITY;
        r_tgt[i] <= UNITY;
      end
    end else begin
      unique case (r_state)
        ST_INIT: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_band  <= eq_band_e'(r_idx);
            r_data  <= UNITY;
          end else if (w_hs) begin
            r_cur[r_idx] <= r_data;
            r_valid      <= 1'b0;
            r_idx        <= r_idx + 2'd1;
            if (w_last) r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (sample_en) begin
            r_tgt[0] <= fx_low_gain;
            r_tgt[1] <= fx_mid_gain;
            r_tgt[2] <= fx_high_gain;
            r_tgt[3] <= fx_presence;
            r_idx    <= 2'd0;
            r_state  <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (w_cur == w_tgt) begin
            r_idx <= r_idx + 2'd1;
            if (w_last) r_state <= ST_IDLE;
          end else begin
            r_valid <= 1'b1;
            r_band  <= eq_band_e'(r_idx);
            r_data  <= w_next;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_hs) begin
            r_cur[r_idx] <= r_data;
            r_valid      <= 1'b0;
            r_idx        <= r_idx + 2'd1;
            r_state      <= w_last ? ST_IDLE
                                   : ST_EVAL;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // A strobe seen outside IDLE is lost; flag it
  // one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovr <= 1'b0;
    end else begin
      r_ovr <= sample_en && (r_state != ST_IDLE);
    end
  end

  assign coef_valid = r_valid;
  assign coef_band  = r_band;
  assign coef_data  = r_data;
  assign busy       = (r_state != ST_IDLE);
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_fx_eq_ctrl.sv
// tb_fx_eq_ctrl: directed + random checks of fx_eq_ctrl.
// Reference model tracks applied band values with plain integers.
module tb_fx_eq_ctrl;

  localparam int W    = 7;
  localparam int STEP = 4;

`ifdef FX_EQ_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         sample_en;
  logic [W-1:0] low, mid, high, pres;
  logic         coef_valid;
  logic         coef_ready;
  logic [1:0]   coef_band;
  logic [W-1:0] coef_data;
  logic         busy;
  logic         overrun;

  always #5 clk = ~clk;

  fx_eq_ctrl #(
    .PARAM_W   (W),
    .RAMP_STEP (STEP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_en    (sample_en),
    .fx_low_gain  (low),
    .fx_mid_gain  (mid),
    .fx_high_gain (high),
    .fx_presence  (pres),
    .coef_valid   (coef_valid),
    .coef_ready   (coef_ready),
    .coef_band    (coef_band),
    .coef_data    (coef_data),
    .busy         (busy),
    .overrun      (overrun)
  );

  int vecs = 0;
  int miss = 0;
  int mcur [4];
  int eb[$], ed[$];
  int qb[$], qd[$];
  bit rnd_ready = 1'b0;

  // Log every accepted write
  always @(posedge clk) begin
    if (!reset && coef_valid && coef_ready) begin
      qb.push_back(int'(coef_band));
      qd.push_back(int'(coef_data));
    end
  end

  function automatic int mnext(int c, int t);
    if (!RAMP) return t;
    if (t > c) return (t - c <= STEP) ? t : c + STEP;
    return (c - t <= STEP) ? t : c - STEP;
  endfunction

  task automatic check(string tag, int obs, int exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic plan(int l, int m, int h, int p);
    int t [4];
    int n;
    t = '{l, m, h, p};
    for (int b = 0; b < 4; b++) begin
      if (mcur[b] != t[b]) begin
        n = mnext(mcur[b], t[b]);
        eb.push_back(b);
        ed.push_back(n);
        mcur[b] = n;
      end
    end
  endtask

  task automatic plan_init();
    for (int b = 0; b < 4; b++) begin
      mcur[b] = 64;
      eb.push_back(b);
      ed.push_back(64);
    end
  endtask

  task automatic sample(int l, int m, int h, int p);
    plan(l, m, h, p);
    low  = W'(l);
    mid  = W'(m);
    high = W'(h);
    pres = W'(p);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while (busy === 1'b1 && n < 300) begin
      if (rnd_ready) coef_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    coef_ready = 1'b1;
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic check_writes(string tag);
    int k;
    check({tag, "_nwr"}, qb.size(), eb.size());
    k = (qb.size() < eb.size()) ? qb.size() : eb.size();
    for (int i = 0; i < k; i++) begin
      check($sformatf("%s_band%0d", tag, i), qb[i], eb[i]);
      check($sformatf("%s_data%0d", tag, i), qd[i], ed[i]);
    end
    qb.delete(); qd.delete();
    eb.delete(); ed.delete();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    sample_en = 1'b0;
    coef_ready = 1'b0;
    low = 7'd64; mid = 7'd64;
    high = 7'd64; pres = 7'd64;
    repeat (3) tick();
    check("rst_valid", int'(coef_valid), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_ovr", int'(overrun), 0);
    check("rst_band", int'(coef_band), 0);
    check("rst_data", int'(coef_data), 64);

    // Release; strobe during INIT is dropped
    plan_init();
    reset = 1'b0;
    coef_ready = 1'b1;
    sample_en = 1'b1;
    low = 7'd5;
    tick();
    sample_en = 1'b0;
    check("init_ovr", int'(overrun), 1);
    wait_idle("init");
    check_writes("init");

    // Low band toward 80, then steady
    for (int s = 0; s < 5; s++) begin
      sample(80, 64, 64, 64);
      wait_idle($sformatf("low%0d", s));
      check_writes($sformatf("low%0d", s));
    end

    // Presence small step, then toward 0
    sample(80, 64, 64, 62);
    wait_idle("pres62");
    check_writes("pres62");
    for (int s = 0; s < 18; s++) begin
      sample(80, 64, 64, 0);
      wait_idle($sformatf("pres0_%0d", s));
      check_writes($sformatf("pres0_%0d", s));
    end

    // Stalled write; latency and stability
    coef_ready = 1'b0;
    sample(mcur[0] ^ 16, mcur[1], mcur[2], mcur[3]);
    check("lat1_valid", int'(coef_valid), 0);
    tick();
    check("lat2_valid", int'(coef_valid), 1);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall_v%0d", k), int'(coef_valid), 1);
      check($sformatf("stall_b%0d", k), int'(coef_band), eb[0]);
      check($sformatf("stall_d%0d", k), int'(coef_data), ed[0]);
      if (k == 1) begin
        sample_en = 1'b1;
        low = 7'd3; mid = 7'd3;
        high = 7'd3; pres = 7'd3;
      end
      tick();
      sample_en = 1'b0;
      if (k == 1) check("stall_ovr", int'(overrun), 1);
      if (k == 2) check("stall_ovr_end", int'(overrun), 0);
    end
    coef_ready = 1'b1;
    wait_idle("stall");
    check_writes("stall");

    // All bands at once
    sample(127, 0, 10, 100);
    wait_idle("all4");
    check_writes("all4");

    // Random knobs with random backpressure
    rnd_ready = 1'b1;
    for (int s = 0; s < 25; s++) begin
      sample($urandom_range(0, 127), $urandom_range(0, 127),
             $urandom_range(0, 127), $urandom_range(0, 127));
      wait_idle($sformatf("rnd%0d", s));
      check_writes($sformatf("rnd%0d", s));
    end
    rnd_ready = 1'b0;
    coef_ready = 1'b1;

    // Reset during the band-1 write
    sample(mcur[0] ^ 32, mcur[1] ^ 32, mcur[2], mcur[3]);
    n = 0;
    while (!(coef_valid === 1'b1 && coef_band === 2'd1)
           && n < 50) begin
      tick();
      n++;
    end
    coef_ready = 1'b0;
    check("b1_seen", int'(coef_valid), 1);
    reset = 1'b1;
    tick();
    tick();
    check("b1_rst_valid", int'(coef_valid), 0);
    check("b1_rst_busy", int'(busy), 1);
    check("b1_nwr", qb.size(), 1);
    if (qb.size() > 0) check("b1_band0", qb[0], 0);
    qb.delete(); qd.delete();
    eb.delete(); ed.delete();
    plan_init();
    reset = 1'b0;
    coef_ready = 1'b1;
    tick();
    wait_idle("reinit");
    check_writes("reinit");

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
